// File: rtl/steer_en_sm.sv
// Rider-presence / steering-enable controller fed by the held A2D load and battery readings.
// state    | meaning
// IDLE     | no rider on the platform
// WAIT     | rider on, waiting for a balanced settle period
// STEER_EN | rider on and settled, steering enabled
module steer_en_sm #(
    parameter logic [11:0] MIN_RIDER_WT = 12'h200,
    parameter logic [11:0] WT_HYST      = 12'h040,
    parameter int          TMR_W        = 26,
    parameter logic [11:0] BATT_LOW     = 12'h800,
    parameter logic [11:0] BATT_HYST    = 12'h030
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [11:0] lft_ld,
    input  logic [11:0] rght_ld,
    input  logic [11:0] batt,
    output logic        en_steer,
    output logic        rider_off,
    output logic        batt_low
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WAIT     = 2'd1,
        STEER_EN = 2'd2
    } state_t;

    localparam logic [12:0] ON_THR   = {1'b0, MIN_RIDER_WT};
    localparam logic [12:0] OFF_THR  = {1'b0, MIN_RIDER_WT} - {1'b0, WT_HYST};
    localparam logic [12:0] BATT_SET = {1'b0, BATT_LOW};
    localparam logic [12:0] BATT_CLR = {1'b0, BATT_LOW} + {1'b0, BATT_HYST};
    localparam logic [TMR_W-1:0] TMR_ONE = {{(TMR_W-1){1'b0}}, 1'b1};

    state_t             r_state;
    state_t             w_state_nxt;
    logic [TMR_W-1:0]   r_tmr;
    logic [TMR_W-1:0]   w_tmr_nxt;
    logic               r_en_steer;
    logic               r_rider_off;
    logic               r_batt_low;
    logic               w_en_steer_nxt;
    logic               w_rider_off_nxt;
    logic               w_batt_low_nxt;

    logic [12:0]        w_sum;
    logic [11:0]        w_diff;
    logic [12:0]        w_diff13;
    logic               w_sum_gt_min;
    logic               w_sum_lt_min;
    logic               w_diff_gt_1_4;
    logic               w_diff_gt_15_16;
    logic               w_tmr_full;
    logic [12:0]        w_batt13;

    assign w_sum           = {1'b0, lft_ld} + {1'b0, rght_ld};
    assign w_diff          = (lft_ld >= rght_ld) ? (lft_ld - rght_ld) : (rght_ld - lft_ld);
    assign w_diff13        = {1'b0, w_diff};
    assign w_sum_gt_min    = (w_sum > ON_THR);
    assign w_sum_lt_min    = (w_sum < OFF_THR);
    assign w_diff_gt_1_4   = (w_diff13 > (w_sum >> 2));
    assign w_diff_gt_15_16 = (w_diff13 > (w_sum - (w_sum >> 4)));
    assign w_tmr_full      = &r_tmr;
    assign w_batt13        = {1'b0, batt};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_tmr       <= '0;
            r_en_steer  <= 1'b0;
            r_rider_off <= 1'b1;
            r_batt_low  <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_tmr       <= w_tmr_nxt;
            r_en_steer  <= w_en_steer_nxt;
            r_rider_off <= w_rider_off_nxt;
            r_batt_low  <= w_batt_low_nxt;
        end
    end

    // Weight loss beats balance checks, which beat the settle timer.
    always_comb begin
        w_state_nxt = r_state;
        w_tmr_nxt   = r_tmr;
        case (r_state)
            IDLE: begin
                if (w_sum_gt_min) begin
                    w_state_nxt = WAIT;
                    w_tmr_nxt   = '0;
                end
            end
            WAIT: begin
                if (w_sum_lt_min) begin
                    w_state_nxt = IDLE;
                end else if (w_diff_gt_1_4) begin
                    w_tmr_nxt = '0;
                end else if (w_tmr_full) begin
                    w_state_nxt = STEER_EN;
                end else begin
                    w_tmr_nxt = r_tmr + TMR_ONE;
                end
            end
            STEER_EN: begin
                if (w_sum_lt_min) begin
                    w_state_nxt = IDLE;
                end else if (w_diff_gt_15_16) begin
                    w_state_nxt = WAIT;
                    w_tmr_nxt   = '0;
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_tmr_nxt   = '0;
            end
        endcase
    end

    always_comb begin
        w_en_steer_nxt  = (w_state_nxt == STEER_EN);
        w_rider_off_nxt = (w_state_nxt == IDLE);
        w_batt_low_nxt  = r_batt_low;
        if (w_batt13 < BATT_SET) begin
            w_batt_low_nxt = 1'b1;
        end else if (w_batt13 >= BATT_CLR) begin
            w_batt_low_nxt = 1'b0;
        end
    end

    assign en_steer  = r_en_steer;
    assign rider_off = r_rider_off;
    assign batt_low  = r_batt_low;

endmodule

// File: tb/tb_steer_en_sm.sv
// Scoreboard bench for steer_en_sm: a behavioural rider model predicts every cycle's outputs.
module tb_steer_en_sm;

    localparam int TMR_W  = 4;
    localparam int SETTLE = 1 << TMR_W;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [11:0] lft_ld = '0;
    logic [11:0] rght_ld = '0;
    logic [11:0] batt = 12'hA00;
    logic        en_steer, rider_off, batt_low;

    steer_en_sm #(.TMR_W(TMR_W)) dut (
        .clk(clk), .rst(rst), .lft_ld(lft_ld), .rght_ld(rght_ld), .batt(batt),
        .en_steer(en_steer), .rider_off(rider_off), .batt_low(batt_low)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic en;
        logic off;
        logic blow;
    } exp_t;

    exp_t exp_q[$];
    int   n_vec = 0;
    int   n_err = 0;

    // Reference model: rider phase plus balanced cycles still owed before steering.
    bit m_on      = 0;
    bit m_steer   = 0;
    int m_owed    = SETTLE;
    bit m_blow    = 0;

    task automatic model_step(input bit r, input int l, input int rt, input int b);
        int  sum, diff;
        bit  heavy, light, tilt, falling;
        exp_t e;
        sum     = l + rt;
        diff    = (l > rt) ? l - rt : rt - l;
        heavy   = sum > 'h200;
        light   = sum < ('h200 - 'h040);
        tilt    = diff > sum / 4;
        falling = diff > sum - sum / 16;
        if (r) begin
            m_on = 0; m_steer = 0; m_owed = SETTLE; m_blow = 0;
        end else begin
            if (!m_on) begin
                if (heavy) begin m_on = 1; m_owed = SETTLE; end
            end else if (light) begin
                m_on = 0; m_steer = 0;
            end else if (m_steer) begin
                if (falling) begin m_steer = 0; m_owed = SETTLE; end
            end else if (tilt) begin
                m_owed = SETTLE;
            end else begin
                m_owed = m_owed - 1;
                if (m_owed == 0) m_steer = 1;
            end
            if (b < 'h800) m_blow = 1;
            else if (b >= 'h830) m_blow = 0;
        end
        e.en   = m_steer;
        e.off  = !m_on;
        e.blow = m_blow;
        exp_q.push_back(e);
    endtask

    task automatic drive(input bit r, input int l, input int rt, input int b, input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            rst = r; lft_ld = 12'(l); rght_ld = 12'(rt); batt = 12'(b);
            model_step(r, l, rt, b);
        end
    endtask

    always @(posedge clk) begin
        exp_t e;
        #1;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_vec++;
            if (en_steer !== e.en) begin
                n_err++;
                $display("FAIL en_steer @%0t: got %b want %b", $time, en_steer, e.en);
            end
            if (rider_off !== e.off) begin
                n_err++;
                $display("FAIL rider_off @%0t: got %b want %b", $time, rider_off, e.off);
            end
            if (batt_low !== e.blow) begin
                n_err++;
                $display("FAIL batt_low @%0t: got %b want %b", $time, batt_low, e.blow);
            end
        end
    end

    task automatic random_phase(input int cycles);
        int done, kind, len, a, bb, bat;
        done = 0;
        while (done < cycles) begin
            kind = int'($urandom_range(0, 6));
            len  = int'($urandom_range(1, 25));
            case (kind)
                0: begin a = int'($urandom_range('h120, 'h1E0)); bb = a + int'($urandom_range(0, 'h20)) - 'h10; end
                1: begin a = int'($urandom_range('h180, 'h300)); bb = a / 2 - int'($urandom_range(0, 'h40)); end
                2: begin a = int'($urandom_range('h250, 'h400)); bb = int'($urandom_range(0, 'h10)); end
                3: begin a = int'($urandom_range(0, 'hD0)); bb = int'($urandom_range(0, 'hD0)); end
                4: begin a = int'($urandom_range('hE0, 'h100)); bb = int'($urandom_range('hE0, 'h100)); end
                5: begin a = int'($urandom_range(0, 'hFFF)); bb = int'($urandom_range(0, 'hFFF)); end
                default: begin a = int'($urandom_range('h100, 'h200)); bb = a; end
            endcase
            if (bb < 0) bb = 0;
            bat = int'($urandom_range('h7C0, 'h860));
            drive(($urandom_range(0, 150) == 0), a, bb, bat, len);
            done += len;
        end
    endtask

    initial begin
        drive(1, 'h3FF, 'h100, 'h700, 2);
        drive(0, 'h050, 'h050, 'hA00, 3);
        drive(0, 'h150, 'h150, 'hA00, SETTLE + 4);
        drive(0, 'h2A0, 'h000, 'hA00, 1);
        drive(0, 'h150, 'h150, 'hA00, SETTLE + 2);
        drive(0, 'h2A0, 'h000, 'hA00, 1);
        drive(0, 'h200, 'h0A0, 'hA00, 40);
        drive(0, 'h150, 'h150, 'hA00, SETTLE + 2);
        drive(0, 'h0F8, 'h0F8, 'hA00, 5);
        drive(0, 'h0D8, 'h0D8, 'hA00, 2);
        drive(0, 'h150, 'h150, 'hA00, SETTLE + 3);
        drive(1, 'h150, 'h150, 'hA00, 1);
        drive(0, 'h000, 'h000, 'h7FF, 2);
        drive(0, 'h000, 'h000, 'h810, 2);
        drive(0, 'h000, 'h000, 'h830, 2);
        random_phase(3000);
        repeat (3) @(negedge clk);
        n_vec++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL scoreboard_drain: got %0d left want 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
